// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC phase generator front end.
//
// Contents:
//   AccWDefault    - default phase accumulator / tuning word width
//   PhaseWDefault  - default output phase width
//   CordicLatency  - pipeline depth of the downstream CORDIC rotator; a bench
//                    delays `arg` by this many cycles to line it up with Re/Im
//   state_e        - generator FSM states
package cordic_pkg;

    localparam int unsigned AccWDefault   = 32;
    localparam int unsigned PhaseWDefault = 16;
    localparam int unsigned CordicLatency = 14;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRunFixed = 2'd1,
        StRunSweep = 2'd2
    } state_e;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with output phase offset.
//
// Each enabled cycle adds the tuning word to the accumulator and registers
// the top PhaseW bits of the new accumulator value plus the phase offset.
// A clear restarts the accumulator at zero and presents the bare offset,
// which is the phase of sample 0.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset; clears accumulator and arg_o
//   clr_i   - restart: acc <= 0, arg_o <= pofs_i (has priority over en_i)
//   en_i    - advance: acc <= acc + ftw_i, arg_o <= top bits + pofs_i
//   ftw_i   - frequency tuning word added per enabled cycle
//   pofs_i  - phase offset added to the output phase
//   arg_o   - registered output phase
module phase_acc
    import cordic_pkg::*;
#(
    parameter int unsigned AccW   = AccWDefault,
    parameter int unsigned PhaseW = PhaseWDefault
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [AccW-1:0]   ftw_i,
    input  logic [PhaseW-1:0] pofs_i,
    output logic [PhaseW-1:0] arg_o
);

    logic [AccW-1:0]   acc_q, acc_d;
    logic [AccW-1:0]   acc_sum;
    logic [PhaseW-1:0] arg_q, arg_d;

    // Wraps modulo 2^AccW, which is exactly the phase wrap we want.
    assign acc_sum = acc_q + ftw_i;

    always_comb begin
        acc_d = acc_q;
        arg_d = arg_q;
        if (clr_i) begin
            acc_d = '0;
            arg_d = pofs_i;
        end else if (en_i) begin
            acc_d = acc_sum;
            arg_d = acc_sum[AccW-1 -: PhaseW] + pofs_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            arg_q <= '0;
        end else begin
            acc_q <= acc_d;
            arg_q <= arg_d;
        end
    end

    assign arg_o = arg_q;

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO-style phase generator feeding the CORDIC rotator `arg` input.
//
// Produces one PhaseW-bit phase per clock from a phase accumulator driven by
// a frequency tuning word (FTW). In sweep mode the FTW ramps by a fixed step
// every cycle until it reaches the stop FTW, then the generator continues at
// that fixed frequency (linear chirp).
//
// Ports:
//   clk_i           - clock, rising edge
//   rst_ni          - asynchronous active-low reset
//   cfg_valid_i     - configuration write strobe (accepted only in idle)
//   cfg_ready_o     - high while idle; a write is taken when both are high
//   cfg_mode_i      - 0 = fixed frequency, 1 = sweep
//   cfg_ftw_i       - start FTW, unsigned
//   cfg_step_i      - FTW increment per cycle in sweep mode, unsigned
//   cfg_stop_ftw_i  - final FTW of the sweep, unsigned
//   cfg_pofs_i      - phase offset added to every output sample
//   start_i         - begin generation (sampled only in idle)
//   stop_i          - abort generation (sampled in any run state)
//   arg_o           - registered phase to the CORDIC
//   arg_valid_o     - arg_o holds a valid sample
//   busy_o          - generator is running
//   sweep_done_o    - one-cycle pulse when the sweep reaches the stop FTW
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int unsigned AccW   = AccWDefault,
    parameter int unsigned PhaseW = PhaseWDefault
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic              cfg_mode_i,
    input  logic [AccW-1:0]   cfg_ftw_i,
    input  logic [AccW-1:0]   cfg_step_i,
    input  logic [AccW-1:0]   cfg_stop_ftw_i,
    input  logic [PhaseW-1:0] cfg_pofs_i,
    input  logic              start_i,
    input  logic              stop_i,
    output logic [PhaseW-1:0] arg_o,
    output logic              arg_valid_o,
    output logic              busy_o,
    output logic              sweep_done_o
);

    state_e state_q, state_d;

    // Configuration registers.
    logic              mode_q;
    logic [AccW-1:0]   ftw_q;
    logic [AccW-1:0]   step_q;
    logic [AccW-1:0]   stop_ftw_q;
    logic [PhaseW-1:0] pofs_q;

    logic [AccW-1:0]   ftw_cur_q, ftw_cur_d;
    logic              arg_valid_q, arg_valid_d;
    logic              busy_q, busy_d;
    logic              sweep_done_q, sweep_done_d;

    logic              cfg_accept;
    logic              mode_eff;
    logic [AccW-1:0]   ftw_eff;
    logic [PhaseW-1:0] pofs_eff;
    logic [AccW:0]     ftw_sum;
    logic              acc_clr;
    logic              acc_en;

    assign cfg_ready_o = (state_q == StIdle);
    assign cfg_accept  = cfg_valid_i & cfg_ready_o;

    // A config write on the same edge as start must take effect for that
    // start, so the start path sees the incoming values rather than the regs.
    assign mode_eff = cfg_accept ? cfg_mode_i : mode_q;
    assign ftw_eff  = cfg_accept ? cfg_ftw_i  : ftw_q;
    assign pofs_eff = cfg_accept ? cfg_pofs_i : pofs_q;

    // One extra bit so a sum past 2^AccW still compares as "reached stop".
    assign ftw_sum = {1'b0, ftw_cur_q} + {1'b0, step_q};

    always_comb begin
        state_d      = state_q;
        ftw_cur_d    = ftw_cur_q;
        arg_valid_d  = arg_valid_q;
        sweep_done_d = 1'b0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    acc_clr     = 1'b1;
                    ftw_cur_d   = ftw_eff;
                    arg_valid_d = 1'b1;
                    state_d     = mode_eff ? StRunSweep : StRunFixed;
                end
            end

            StRunFixed: begin
                if (stop_i) begin
                    state_d     = StIdle;
                    arg_valid_d = 1'b0;
                end else begin
                    acc_en = 1'b1;
                end
            end

            StRunSweep: begin
                if (stop_i) begin
                    // Abort wins over a coincident sweep completion.
                    state_d     = StIdle;
                    arg_valid_d = 1'b0;
                end else begin
                    // The accumulator uses the old ftw_cur this edge.
                    acc_en = 1'b1;
                    if (ftw_sum >= {1'b0, stop_ftw_q}) begin
                        ftw_cur_d    = stop_ftw_q;
                        sweep_done_d = 1'b1;
                        state_d      = StRunFixed;
                    end else begin
                        ftw_cur_d = ftw_sum[AccW-1:0];
                    end
                end
            end

            default: begin
                state_d     = StIdle;
                arg_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ftw_cur_q    <= '0;
            arg_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ftw_cur_q    <= ftw_cur_d;
            arg_valid_q  <= arg_valid_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= 1'b0;
            ftw_q      <= '0;
            step_q     <= '0;
            stop_ftw_q <= '0;
            pofs_q     <= '0;
        end else if (cfg_accept) begin
            mode_q     <= cfg_mode_i;
            ftw_q      <= cfg_ftw_i;
            step_q     <= cfg_step_i;
            stop_ftw_q <= cfg_stop_ftw_i;
            pofs_q     <= cfg_pofs_i;
        end
    end

    phase_acc #(
        .AccW   (AccW),
        .PhaseW (PhaseW)
    ) u_phase_acc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (acc_clr),
        .en_i   (acc_en),
        .ftw_i  (ftw_cur_q),
        .pofs_i (pofs_eff),
        .arg_o  (arg_o)
    );

    assign arg_valid_o  = arg_valid_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = sweep_done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen. Expected phases come from a
// closed-form model: the FTW used on run edge j is the start FTW for j = 0
// and min(start + j*step, stop) afterwards in sweep mode; sample n is the
// sum of the first n FTWs, mod 2^32, top 16 bits, plus the offset.
module tb_cordic_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_mode;
    logic [31:0] cfg_ftw;
    logic [31:0] cfg_step;
    logic [31:0] cfg_stop_ftw;
    logic [15:0] cfg_pofs;
    logic        start;
    logic        stop;
    logic [15:0] arg;
    logic        arg_valid;
    logic        busy;
    logic        sweep_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cordic_phase_gen dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_mode_i     (cfg_mode),
        .cfg_ftw_i      (cfg_ftw),
        .cfg_step_i     (cfg_step),
        .cfg_stop_ftw_i (cfg_stop_ftw),
        .cfg_pofs_i     (cfg_pofs),
        .start_i        (start),
        .stop_i         (stop),
        .arg_o          (arg),
        .arg_valid_o    (arg_valid),
        .busy_o         (busy),
        .sweep_done_o   (sweep_done)
    );

    // ---------------- reference model ----------------
    function automatic longint ftw_at(bit mode, longint f0, longint st, longint sp, int j);
        longint v;
        if (!mode || j == 0) return f0;
        v = f0 + longint'(j) * st;
        return (v < sp) ? v : sp;
    endfunction

    function automatic logic [15:0] model_arg(bit mode, longint f0, longint st, longint sp,
                                              logic [15:0] pofs, int n);
        longint ph = 0;
        for (int j = 0; j < n; j++) ph += ftw_at(mode, f0, st, sp, j);
        ph = ph & 64'h0000_0000_FFFF_FFFF;
        return 16'(ph >> 16) + pofs;
    endfunction

    // Run edge (1-based) on which sweep_done is expected, or -1 for never.
    function automatic int model_done_edge(bit mode, longint f0, longint st, longint sp);
        if (!mode) return -1;
        if (f0 + st >= sp) return 1;
        if (st == 0) return -1;
        return int'((sp - f0 + st - 1) / st);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_cfg(input logic m, input logic [31:0] f, input logic [31:0] s,
                             input logic [31:0] sp, input logic [15:0] p);
        cfg_mode = m; cfg_ftw = f; cfg_step = s; cfg_stop_ftw = sp; cfg_pofs = p;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;  // must be ignored during reset
        #12;
        n_tests++;
        if (arg !== 16'h0 || arg_valid !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: arg=%h valid=%b busy=%b done=%b, expected all 0",
                     arg, arg_valid, busy, sweep_done);
        end
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        n_tests++;
        if (arg_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b busy=%b expected 0 0", arg_valid, busy);
        end
    endtask

    task automatic test_fixed_ramp();
        logic [15:0] e;
        apply_cfg(1'b0, 32'h0001_0000, 32'h0, 32'h0, 16'h0);
        do_start();
        for (int n = 0; n <= 65536; n++) begin
            if (n > 0) tick();
            e = 16'(((longint'(n) * 64'h1_0000) & 64'hFFFF_FFFF) >> 16);
            n_tests++;
            if (arg !== e || arg_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp n=%0d: arg=%h valid=%b busy=%b, expected arg=%h valid=1 busy=1",
                         n, arg, arg_valid, busy, e);
                break;
            end
        end
        do_stop();
    endtask

    task automatic test_fixed_half();
        logic [15:0] e;
        apply_cfg(1'b0, 32'h8000_0000, 32'h0, 32'h0, 16'h4000);
        do_start();
        for (int n = 0; n < 12; n++) begin
            if (n > 0) tick();
            e = (n % 2 == 0) ? 16'h4000 : 16'hC000;
            n_tests++;
            if (arg !== e || arg_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL half n=%0d: arg=%h valid=%b expected %h valid=1",
                         n, arg, arg_valid, e);
            end
        end
        do_stop();
    endtask

    task automatic test_sweep();
        logic [15:0] e;
        logic [15:0] done_arg;
        int          dones;
        int          de;
        dones    = 0;
        done_arg = 16'hFFFF;
        de       = model_done_edge(1'b1, 64'h1_0000, 64'h1_0000, 64'h4_0000);
        apply_cfg(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0004_0000, 16'h0);
        do_start();
        for (int n = 0; n < 12; n++) begin
            if (n > 0) tick();
            e = model_arg(1'b1, 64'h1_0000, 64'h1_0000, 64'h4_0000, 16'h0, n);
            n_tests++;
            if (arg !== e || arg_valid !== 1'b1 || busy !== 1'b1 || sweep_done !== (n == de)) begin
                n_fail++;
                $display("FAIL sweep n=%0d: arg=%h valid=%b busy=%b done=%b, expected arg=%h 1 1 %b",
                         n, arg, arg_valid, busy, sweep_done, e, (n == de));
            end
            if (sweep_done === 1'b1) begin
                dones++;
                done_arg = arg;
            end
        end
        n_tests++;
        if (dones !== 1 || done_arg !== 16'd6) begin
            n_fail++;
            $display("FAIL sweep_done_once: pulses=%0d arg_at_done=%0d, expected 1 and 6",
                     dones, done_arg);
        end
        do_stop();
        // Stop on the completion edge: idle wins, no pulse.
        do_start();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if (sweep_done !== 1'b0 || arg_valid !== 1'b0 || busy !== 1'b0 || arg !== 16'd3) begin
            n_fail++;
            $display("FAIL stop_at_done: done=%b valid=%b busy=%b arg=%h, expected 0 0 0 0003",
                     sweep_done, arg_valid, busy, arg);
        end
    endtask

    task automatic test_stop();
        apply_cfg(1'b0, 32'h0001_0000, 32'h0, 32'h0, 16'h0);
        do_start();
        for (int n = 1; n <= 5; n++) begin
            // Config writes while running must be dropped.
            if (n == 2) begin
                cfg_ftw = 32'h0003_0000; cfg_pofs = 16'h0777; cfg_valid = 1'b1;
            end
            if (n == 4) cfg_valid = 1'b0;
            tick();
        end
        n_tests++;
        if (arg !== 16'd5) begin
            n_fail++;
            $display("FAIL stop_pre: arg=%h expected 0005", arg);
        end
        do_stop();
        n_tests++;
        if (arg_valid !== 1'b0 || busy !== 1'b0 || arg !== 16'd5 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_post: valid=%b busy=%b arg=%h ready=%b, expected 0 0 0005 1",
                     arg_valid, busy, arg, cfg_ready);
        end
        tick();
        n_tests++;
        if (arg_valid !== 1'b0 || arg !== 16'd5) begin
            n_fail++;
            $display("FAIL stop_hold: valid=%b arg=%h expected 0 0005", arg_valid, arg);
        end
        do_start();
        n_tests++;
        if (arg !== 16'h0) begin
            n_fail++;
            $display("FAIL cfg_ignored_pofs: arg=%h expected 0000", arg);
        end
        tick();
        n_tests++;
        if (arg !== 16'h1) begin
            n_fail++;
            $display("FAIL cfg_ignored_ftw: arg=%h expected 0001", arg);
        end
        do_stop();
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_tests++;
        if (arg_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_and_stop: valid=%b busy=%b ready=%b expected 0 0 1",
                     arg_valid, busy, cfg_ready);
        end
        cfg_mode = 1'b0; cfg_ftw = 32'h0001_0000; cfg_step = 32'h0;
        cfg_stop_ftw = 32'h0; cfg_pofs = 16'h0100;
        cfg_valid = 1'b1;
        start     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        n_tests++;
        if (arg !== 16'h0100 || arg_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_with_start: arg=%h valid=%b expected 0100 1", arg, arg_valid);
        end
        tick();
        n_tests++;
        if (arg !== 16'h0101) begin
            n_fail++;
            $display("FAIL cfg_with_start_next: arg=%h expected 0101", arg);
        end
        do_stop();
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        int          de;
        apply_cfg(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0004_0000, 16'h0);
        do_start();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (arg !== 16'h0 || arg_valid !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0
            || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: arg=%h valid=%b busy=%b done=%b ready=%b expected 0 0 0 0 1",
                     arg, arg_valid, busy, sweep_done, cfg_ready);
        end
        #4 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            n_tests++;
            if (arg_valid !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0 || arg !== 16'h0) begin
                n_fail++;
                $display("FAIL post_reset n=%0d: valid=%b busy=%b done=%b arg=%h expected 0",
                         n, arg_valid, busy, sweep_done, arg);
            end
        end
        // Config was cleared: fixed mode, FTW 0, offset 0.
        do_start();
        tick();
        n_tests++;
        if (arg !== 16'h0 || arg_valid !== 1'b1 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_cleared: arg=%h valid=%b done=%b expected 0000 1 0",
                     arg, arg_valid, sweep_done);
        end
        do_stop();
        de = model_done_edge(1'b1, 64'h1_0000, 64'h1_0000, 64'h4_0000);
        apply_cfg(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0004_0000, 16'h0);
        do_start();
        for (int n = 0; n < 6; n++) begin
            if (n > 0) tick();
            e = model_arg(1'b1, 64'h1_0000, 64'h1_0000, 64'h4_0000, 16'h0, n);
            n_tests++;
            if (arg !== e || sweep_done !== (n == de)) begin
                n_fail++;
                $display("FAIL restart n=%0d: arg=%h done=%b expected %h %b",
                         n, arg, sweep_done, e, (n == de));
            end
        end
        do_stop();
    endtask

    task automatic test_random();
        logic        m;
        logic [31:0] f, s, sp;
        logic [15:0] p, e, last;
        int          de;
        for (int it = 0; it < 12; it++) begin
            m  = 1'($urandom % 2);
            f  = $urandom;
            s  = ($urandom % 2 == 1) ? $urandom : 32'($urandom_range(0, 1 << 22));
            sp = $urandom;
            p  = 16'($urandom);
            de = model_done_edge(m, f, s, sp);
            if ($urandom % 2 == 1) begin
                cfg_mode = m; cfg_ftw = f; cfg_step = s; cfg_stop_ftw = sp; cfg_pofs = p;
                cfg_valid = 1'b1;
                start     = 1'b1;
                tick();
                cfg_valid = 1'b0;
                start     = 1'b0;
            end else begin
                apply_cfg(m, f, s, sp, p);
                do_start();
            end
            for (int n = 0; n < 30; n++) begin
                if (n > 0) tick();
                e = model_arg(m, f, s, sp, p, n);
                n_tests++;
                if (arg !== e || arg_valid !== 1'b1 || busy !== 1'b1 || sweep_done !== (n == de)) begin
                    n_fail++;
                    $display("FAIL rand it=%0d n=%0d: arg=%h valid=%b busy=%b done=%b, expected %h 1 1 %b",
                             it, n, arg, arg_valid, busy, sweep_done, e, (n == de));
                end
            end
            last = model_arg(m, f, s, sp, p, 29);
            do_stop();
            n_tests++;
            if (arg_valid !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0 || arg !== last) begin
                n_fail++;
                $display("FAIL rand_stop it=%0d: valid=%b busy=%b done=%b arg=%h expected 0 0 0 %h",
                         it, arg_valid, busy, sweep_done, arg, last);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 1'b0; cfg_ftw = '0; cfg_step = '0;
        cfg_stop_ftw = '0; cfg_pofs = '0; start = 1'b0; stop = 1'b0;
        test_reset();
        test_fixed_ramp();
        test_fixed_half();
        test_sweep();
        test_stop();
        test_start_stop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
